// File: rtl/elevator_car.sv
// Elevator car: owns floor position and door mechanics, driven by door_open/updown commands.
// Optional `ELEVATOR_CAR_DOOR_REOPEN_EN lets door_open reverse a closing door.
module elevator_car #(
   parameter int NUM_FLOORS    = 8,
   parameter int FLOOR_W       = 3,
   parameter int TRAVEL_CYCLES = 10,
   parameter int DOOR_CYCLES   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               door_open,
   input  logic [1:0]         updown,
   output logic               door,
   output logic [FLOOR_W-1:0] floor,
   output logic               moving,
   output logic               fault
);

   localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

   localparam logic [1:0] CMD_STOP = 2'b00;
   localparam logic [1:0] CMD_UP   = 2'b01;
   localparam logic [1:0] CMD_DOWN = 2'b10;
   localparam logic [1:0] CMD_ILL  = 2'b11;

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_MOVE_UP      = 3'd1;
   localparam logic [2:0] S_MOVE_DOWN    = 3'd2;
   localparam logic [2:0] S_DOOR_OPENING = 3'd3;
   localparam logic [2:0] S_DOOR_OPEN    = 3'd4;
   localparam logic [2:0] S_DOOR_CLOSING = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FLOOR_W-1:0] floor_q, floor_d;
   logic               pending_q, pending_d;
   logic               fault_q, fault_d;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      floor_d   = floor_q;
      pending_d = pending_q;
      fault_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (door_open) begin
               state_d = S_DOOR_OPENING;
               cnt_d   = DOOR_LOAD;
            end else if (updown == CMD_UP && floor_q != TOP_FLOOR) begin
               state_d = S_MOVE_UP;
               cnt_d   = TRAVEL_LOAD;
            end else if (updown == CMD_DOWN && floor_q != '0) begin
               state_d = S_MOVE_DOWN;
               cnt_d   = TRAVEL_LOAD;
            end else if (updown != CMD_STOP) begin
               fault_d = 1'b1;
            end
         end

         S_MOVE_UP, S_MOVE_DOWN: begin
            // Reversal is never honoured mid-transit; only the illegal code is flagged.
            fault_d = (updown == CMD_ILL);
            if (door_open) pending_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               floor_d = (state_q == S_MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
               if (pending_q || door_open) begin
                  state_d   = S_DOOR_OPENING;
                  cnt_d     = DOOR_LOAD;
                  pending_d = 1'b0;
               end else if ((state_q == S_MOVE_UP && updown == CMD_UP && floor_d != TOP_FLOOR) ||
                            (state_q == S_MOVE_DOWN && updown == CMD_DOWN && floor_d != '0)) begin
                  cnt_d = TRAVEL_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_DOOR_OPENING: begin
            fault_d = (updown != CMD_STOP);
            if (cnt_q == '0) state_d = S_DOOR_OPEN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end

         S_DOOR_OPEN: begin
            fault_d = (updown != CMD_STOP);
            if (!door_open) begin
               state_d = S_DOOR_CLOSING;
               cnt_d   = DOOR_LOAD;
            end
         end

         S_DOOR_CLOSING: begin
            fault_d = (updown != CMD_STOP);
`ifdef ELEVATOR_CAR_DOOR_REOPEN_EN
            // Reopening takes as long as the door has already spent closing.
            if (door_open) begin
               state_d = S_DOOR_OPENING;
               cnt_d   = DOOR_LOAD - cnt_q;
            end else if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
`else
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
`endif
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         floor_q   <= '0;
         pending_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         floor_q   <= floor_d;
         pending_q <= pending_d;
         fault_q   <= fault_d;
      end
   end

   assign floor  = floor_q;
   assign fault  = fault_q;
   assign door   = (state_q == S_DOOR_OPEN);
   assign moving = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);

endmodule

// File: tb/tb_elevator_car.sv
// Scoreboard bench for elevator_car: a driver steps a behavioural car model and queues
// the expected outputs; an independent monitor pops and compares one entry per clock edge.
module tb_elevator_car;

   localparam int NF = 8;
   localparam int FW = 3;
   localparam int TC = 4;
   localparam int DC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          door_open = 1'b0;
   logic [1:0]    updown = 2'b00;
   logic          door;
   logic [FW-1:0] floor;
   logic          moving;
   logic          fault;

   elevator_car #(
      .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
   ) dut (
      .clk(clk), .rst(rst), .door_open(door_open), .updown(updown),
      .door(door), .floor(floor), .moving(moving), .fault(fault)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [FW-1:0] floor;
      logic          door;
      logic          moving;
      logic          fault;
   } obs_t;

   obs_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural car: what it is doing, where it is, and how many edges until the activity ends.
   typedef enum {M_IDLE, M_TRAVEL, M_OPENING, M_OPEN, M_CLOSING} activity_t;
   activity_t act = M_IDLE;
   int        pos = 0;
   int        dir = 0;
   int        left = 0;
   bit        want_door = 1'b0;

   task automatic model_reset();
      act = M_IDLE; pos = 0; dir = 0; left = 0; want_door = 1'b0;
   endtask

   task automatic model_step(input bit dop, input logic [1:0] ud, output bit flt);
      flt = 1'b0;
      case (act)
         M_IDLE: begin
            if (dop) begin
               act = M_OPENING; left = DC;
            end else if (ud == 2'b01 && pos < NF - 1) begin
               act = M_TRAVEL; dir = 1; left = TC;
            end else if (ud == 2'b10 && pos > 0) begin
               act = M_TRAVEL; dir = -1; left = TC;
            end else if (ud != 2'b00) begin
               flt = 1'b1;
            end
         end
         M_TRAVEL: begin
            if (dop) want_door = 1'b1;
            if (ud == 2'b11) flt = 1'b1;
            left--;
            if (left == 0) begin
               pos += dir;
               if (want_door) begin
                  act = M_OPENING; left = DC; want_door = 1'b0;
               end else if (ud == ((dir > 0) ? 2'b01 : 2'b10) && pos + dir >= 0 && pos + dir <= NF - 1) begin
                  left = TC;
               end else begin
                  act = M_IDLE;
               end
            end
         end
         M_OPENING: begin
            if (ud != 2'b00) flt = 1'b1;
            left--;
            if (left == 0) act = M_OPEN;
         end
         M_OPEN: begin
            if (ud != 2'b00) flt = 1'b1;
            if (!dop) begin
               act = M_CLOSING; left = DC;
            end
         end
         M_CLOSING: begin
            if (ud != 2'b00) flt = 1'b1;
`ifdef ELEVATOR_CAR_DOOR_REOPEN_EN
            if (dop) begin
               act = M_OPENING; left = DC - left + 1;
            end else begin
               left--;
               if (left == 0) act = M_IDLE;
            end
`else
            left--;
            if (left == 0) act = M_IDLE;
`endif
         end
         default: act = M_IDLE;
      endcase
   endtask

   task automatic cycle(input bit dop, input logic [1:0] ud);
      bit   flt;
      obs_t e;
      @(negedge clk);
      door_open = dop;
      updown    = ud;
      model_step(dop, ud, flt);
      e.floor  = pos[FW-1:0];
      e.door   = (act == M_OPEN);
      e.moving = (act == M_TRAVEL);
      e.fault  = flt;
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic do_reset();
      #2;
      door_open = 1'b0;
      updown    = 2'b00;
      rst       = 1'b1;
      model_reset();
      #1;
      check("rst_floor",  32'(floor),  32'd0);
      check("rst_door",   32'(door),   32'd0);
      check("rst_moving", 32'(moving), 32'd0);
      check("rst_fault",  32'(fault),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic settle();
      for (int i = 0; i < 64 && act != M_IDLE; i++) cycle(1'b0, 2'b00);
   endtask

   task automatic goto_floor(input int target);
      settle();
      for (int i = 0; i < 2 * NF && pos != target; i++) begin
         cycle(1'b0, (pos < target) ? 2'b01 : 2'b10);
         repeat (TC) cycle(1'b0, 2'b00);
      end
   endtask

   task automatic open_and_hold();
      for (int i = 0; i < 16 && act != M_OPEN; i++) cycle(1'b1, 2'b00);
   endtask

   // Monitor: every edge the DUT presents a new output set, compared against the oldest expectation.
   initial begin : monitor
      obs_t e;
      int   n;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n++;
            check($sformatf("edge%0d {floor,door,moving,fault}", n),
                  32'({floor, door, moving, fault}), 32'(e));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      int   len;
      int   r;
      bit   dop;
      logic [1:0] ud;

      do_reset();

      // Multi-floor up run then stop.
      repeat (12) cycle(1'b0, 2'b01);
      repeat (2)  cycle(1'b0, 2'b00);

      // Bottom boundary and illegal code in IDLE.
      goto_floor(0);
      cycle(1'b0, 2'b10);
      cycle(1'b0, 2'b00);
      cycle(1'b0, 2'b11);
      cycle(1'b0, 2'b00);

      // Open requested one cycle into a transit.
      cycle(1'b0, 2'b01);
      cycle(1'b1, 2'b00);
      repeat (8) cycle(1'b0, 2'b00);
      settle();

      // Interlock while the door is open; illegal code during travel.
      open_and_hold();
      cycle(1'b1, 2'b01);
      cycle(1'b1, 2'b00);
      settle();
      cycle(1'b0, 2'b01);
      cycle(1'b0, 2'b11);
      cycle(1'b0, 2'b10);
      settle();

      // Top boundary.
      goto_floor(7);
      cycle(1'b0, 2'b01);
      cycle(1'b0, 2'b00);

      // Door and direction together in IDLE.
      goto_floor(4);
      cycle(1'b1, 2'b10);
      repeat (4) cycle(1'b1, 2'b00);
      settle();

      // Open request reasserted one cycle into closing.
      open_and_hold();
      cycle(1'b0, 2'b00);
      repeat (7) cycle(1'b1, 2'b00);
      repeat (2) cycle(1'b0, 2'b00);
      settle();

      // Reset while travelling up through floor 3.
      goto_floor(2);
      for (int i = 0; i < 32 && !(pos == 3 && act == M_TRAVEL); i++) cycle(1'b0, 2'b01);
      do_reset();
      repeat (6) cycle(1'b0, 2'b00);

      // Randomized command segments.
      repeat (150) begin
         dop = ($urandom_range(0, 9) < 3);
         r   = $urandom_range(0, 9);
         ud  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         len = $urandom_range(1, 8);
         repeat (len) cycle(dop, ud);
      end
      settle();

      repeat (2) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
